// File: rtl/packet_dispatcher.sv
// One-entry staging dispatcher: routes each upstream packet to a per-core queue by its ID field.
// Optional per-queue dispatch counters are built when DISPATCH_STATS_EN is defined.
module packet_dispatcher #(
    parameter int unsigned NUMBER_OF_QUEUES = 4,
    parameter int unsigned DATA_SIZE        = 678,
    parameter int unsigned ID_OFFSET        = 0,
    parameter int unsigned COUNTER_SIZE     = 32
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [DATA_SIZE-1:0]                   in_packet,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUMBER_OF_QUEUES-1:0]            queues_full,
    input  logic                                   pool_empty,
    input  logic                                   pool_last,
    output logic [DATA_SIZE-1:0]                   dispatcher_to_queues_packet,
    output logic [NUMBER_OF_QUEUES-1:0]            dispatcher_to_queues_valid,
    output logic                                   invalid_id,
    output logic                                   stall,
    output logic [NUMBER_OF_QUEUES*COUNTER_SIZE-1:0] dispatched_count
);

    localparam int unsigned QW = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1;
    localparam logic [QW:0] NQ_W = NUMBER_OF_QUEUES[QW:0];

    typedef enum logic {
        EMPTY,
        LOADED
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_SIZE-1:0]  stage_q, stage_d;
    logic                  prev_fire_q, prev_fire_d;
    logic [QW-1:0]         prev_q_q, prev_q_d;
    logic                  prev_pool_last_q, prev_pool_last_d;

    logic [QW-1:0]         q;
    logic                  loaded;
    logic                  bad;
    logic                  full_sel;
    logic                  hazard;
    logic                  fire;
    logic                  drop;

    // Decisions are gated by reset so a staged packet never leaves in a reset cycle.
    always_comb begin
        q        = stage_q[ID_OFFSET +: QW];
        loaded   = reset && (state_q == LOADED);
        bad      = ({1'b0, q} >= NQ_W);
        full_sel = 1'b1;
        if (!bad) begin
            full_sel = queues_full[q];
        end
        // Full/empty flags lag a push by one cycle, so the previous target is unsafe.
        hazard   = prev_fire_q && ((prev_q_q == q) || prev_pool_last_q);
        fire     = loaded && !bad && !full_sel && !pool_empty && !hazard;
        drop     = loaded && bad;
    end

    always_comb begin
        stall                       = loaded && !fire && !drop;
        invalid_id                  = drop;
        in_ready                    = reset && ((state_q == EMPTY) || fire || drop);
        dispatcher_to_queues_packet = stage_q;
        dispatcher_to_queues_valid  = '0;
        for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (fire && (q == QW'(i))) begin
                dispatcher_to_queues_valid[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        stage_d          = stage_q;
        prev_fire_d      = fire;
        prev_q_d         = q;
        prev_pool_last_d = pool_last && fire;
        case (state_q)
            EMPTY: begin
                if (in_valid && in_ready) begin
                    state_d = LOADED;
                    stage_d = in_packet;
                end
            end
            LOADED: begin
                if (fire || drop) begin
                    if (in_valid) begin
                        stage_d = in_packet;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= EMPTY;
            stage_q          <= '0;
            prev_fire_q      <= 1'b0;
            prev_q_q         <= '0;
            prev_pool_last_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            stage_q          <= stage_d;
            prev_fire_q      <= prev_fire_d;
            prev_q_q         <= prev_q_d;
            prev_pool_last_q <= prev_pool_last_d;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [COUNTER_SIZE-1:0] count_q [NUMBER_OF_QUEUES];
    logic [COUNTER_SIZE-1:0] count_d [NUMBER_OF_QUEUES];

    always_comb begin
        dispatched_count = '0;
        for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
            count_d[i] = count_q[i] + COUNTER_SIZE'(dispatcher_to_queues_valid[i]);
            dispatched_count[i*COUNTER_SIZE +: COUNTER_SIZE] = count_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end
`else
    assign dispatched_count = '0;
`endif

endmodule

// File: tb/tb_packet_dispatcher.sv
// Scoreboard bench for packet_dispatcher: default 4-queue instance plus a 3-queue instance for ID drops.
`timescale 1ns/1ps
module tb_packet_dispatcher;

    typedef struct packed {
        logic         drop;
        logic [3:0]   strobe;
        logic [677:0] pkt;
    } exp_t;

    logic           clock;
    logic           reset;
    logic [677:0]   in_packet;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     queues_full;
    logic           pool_empty;
    logic           pool_last;
    logic [677:0]   pkt;
    logic [3:0]     dv;
    logic           inv;
    logic           stall;
    logic [127:0]   dispatched_count;

    logic [15:0]    in_packet3;
    logic           in_valid3;
    logic           in_ready3;
    logic [2:0]     queues_full3;
    logic           pool0;
    logic [15:0]    pkt3;
    logic [2:0]     dv3;
    logic           inv3;
    logic           stall3;
    logic [95:0]    dispatched_count3;

    int n_vec = 0;
    int n_bad = 0;
    exp_t sb[$];
    exp_t sb3[$];
    exp_t em;
    exp_t em3;

    packet_dispatcher #(
        .NUMBER_OF_QUEUES(4),
        .DATA_SIZE(678),
        .ID_OFFSET(0),
        .COUNTER_SIZE(32)
    ) dut (
        .clock(clock), .reset(reset),
        .in_packet(in_packet), .in_valid(in_valid), .in_ready(in_ready),
        .queues_full(queues_full), .pool_empty(pool_empty), .pool_last(pool_last),
        .dispatcher_to_queues_packet(pkt), .dispatcher_to_queues_valid(dv),
        .invalid_id(inv), .stall(stall), .dispatched_count(dispatched_count)
    );

    packet_dispatcher #(
        .NUMBER_OF_QUEUES(3),
        .DATA_SIZE(16),
        .ID_OFFSET(0),
        .COUNTER_SIZE(32)
    ) dut3 (
        .clock(clock), .reset(reset),
        .in_packet(in_packet3), .in_valid(in_valid3), .in_ready(in_ready3),
        .queues_full(queues_full3), .pool_empty(pool0), .pool_last(pool0),
        .dispatcher_to_queues_packet(pkt3), .dispatcher_to_queues_valid(dv3),
        .invalid_id(inv3), .stall(stall3), .dispatched_count(dispatched_count3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [699:0] act, input logic [699:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [677:0] mk(input logic [1:0] id, input logic [31:0] tag);
        logic [677:0] p;
        p = '0;
        p[1:0] = id;
        p[300 +: 32] = ~tag;
        p[677:646] = tag;
        return p;
    endfunction

    task automatic push(input logic [3:0] s, input logic [677:0] p);
        exp_t e;
        e.drop = 1'b0;
        e.strobe = s;
        e.pkt = p;
        sb.push_back(e);
    endtask

    task automatic push3(input logic d, input logic [2:0] s, input logic [15:0] p);
        exp_t e;
        e.drop = d;
        e.strobe = {1'b0, s};
        e.pkt = {662'd0, p};
        sb3.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    // Monitors: every strobe or drop the DUT presents consumes one scoreboard entry.
    always @(negedge clock) begin
        if (dv !== 4'b0000) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected: strobe %b expected no strobe", dv);
            end else begin
                em = sb.pop_front();
                chk("sb_strobe", 700'(dv), 700'(em.strobe));
                chk("sb_packet", 700'(pkt), 700'(em.pkt));
            end
        end
    end

    always @(negedge clock) begin
        if (dv3 !== 3'b000 || inv3 !== 1'b0) begin
            if (sb3.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb3_unexpected: strobe %b invalid_id %b expected nothing", dv3, inv3);
            end else begin
                em3 = sb3.pop_front();
                chk("sb3_drop", 700'(inv3), 700'(em3.drop));
                chk("sb3_strobe", 700'(dv3), 700'(em3.strobe[2:0]));
                if (!em3.drop) begin
                    chk("sb3_packet", 700'(pkt3), 700'(em3.pkt[15:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [677:0] pa, pb, pc;
        logic [127:0] exp_cnt;
        logic [95:0]  exp_cnt3;
        reset = 1'b0; in_valid = 1'b0; in_packet = '0; queues_full = '0;
        pool_empty = 1'b0; pool_last = 1'b0;
        in_valid3 = 1'b0; in_packet3 = '0; queues_full3 = '0; pool0 = 1'b0;

        step(); at_neg();
        chk("rst_in_ready", 700'(in_ready), 700'(0));
        chk("rst_strobe", 700'(dv), 700'(0));
        chk("rst_stall", 700'(stall), 700'(0));
        chk("rst_invalid", 700'(inv), 700'(0));
        chk("rst_packet", 700'(pkt), 700'(0));
        step(); reset = 1'b1; at_neg();
        chk("post_rst_ready", 700'(in_ready), 700'(1));

        // Back-to-back to different queues: full throughput.
        step(); pa = mk(2'd2, 32'd1); in_packet = pa; in_valid = 1'b1; push(4'b0100, pa); at_neg();
        chk("t1_ready0", 700'(in_ready), 700'(1));
        step(); pb = mk(2'd0, 32'd2); in_packet = pb; push(4'b0001, pb); at_neg();
        chk("t1_strobe_q2", 700'(dv), 700'(4'b0100));
        chk("t1_ready1", 700'(in_ready), 700'(1));
        step(); in_valid = 1'b0; at_neg();
        chk("t1_strobe_q0", 700'(dv), 700'(4'b0001));
        chk("t1_ready2", 700'(in_ready), 700'(1));

        // Same queue back-to-back: one hazard stall.
        step(); pa = mk(2'd1, 32'd3); in_packet = pa; in_valid = 1'b1; push(4'b0010, pa); at_neg();
        chk("t2_idle", 700'(dv), 700'(0));
        step(); pb = mk(2'd1, 32'd4); in_packet = pb; push(4'b0010, pb); at_neg();
        chk("t2_first", 700'(dv), 700'(4'b0010));
        step(); in_valid = 1'b0; at_neg();
        chk("t2_hazard_stall", 700'(stall), 700'(1));
        chk("t2_hazard_strobe", 700'(dv), 700'(0));
        chk("t2_hazard_ready", 700'(in_ready), 700'(0));
        step(); at_neg();
        chk("t2_second", 700'(dv), 700'(4'b0010));
        chk("t2_no_stall", 700'(stall), 700'(0));

        // Queue 3 full for five cycles.
        step(); pc = mk(2'd3, 32'd5); in_packet = pc; in_valid = 1'b1; queues_full = 4'b1000;
        push(4'b1000, pc); at_neg();
        chk("t3_accept", 700'(in_ready), 700'(1));
        for (int i = 0; i < 5; i++) begin
            step(); in_packet = mk(2'(i), 32'hdead0000 + 32'(i)); in_valid = 1'b1; at_neg();
            chk("t3_stall", 700'(stall), 700'(1));
            chk("t3_ready", 700'(in_ready), 700'(0));
            chk("t3_strobe", 700'(dv), 700'(0));
            chk("t3_bus_hold", 700'(pkt), 700'(pc));
        end
        step(); queues_full = '0; in_valid = 1'b0; at_neg();
        chk("t3_release", 700'(dv), 700'(4'b1000));
        chk("t3_release_bus", 700'(pkt), 700'(pc));

        // Pool empty blocks; pool_last forces one bubble.
        step(); pa = mk(2'd0, 32'd6); in_packet = pa; in_valid = 1'b1; pool_empty = 1'b1;
        push(4'b0001, pa); at_neg();
        chk("t4_accept", 700'(in_ready), 700'(1));
        step(); in_valid = 1'b0; at_neg();
        chk("t4_pool_stall", 700'(stall), 700'(1));
        chk("t4_pool_strobe", 700'(dv), 700'(0));
        step(); pool_empty = 1'b0; pool_last = 1'b1; pb = mk(2'd2, 32'd7); in_packet = pb;
        in_valid = 1'b1; push(4'b0100, pb); at_neg();
        chk("t4_fire_q0", 700'(dv), 700'(4'b0001));
        chk("t4_refill", 700'(in_ready), 700'(1));
        step(); pool_last = 1'b0; in_valid = 1'b0; at_neg();
        chk("t4_bubble_stall", 700'(stall), 700'(1));
        chk("t4_bubble_strobe", 700'(dv), 700'(0));
        step(); at_neg();
        chk("t4_fire_q2", 700'(dv), 700'(4'b0100));

        // Reset while loaded and stalled discards the staged packet.
        step(); pa = mk(2'd1, 32'd8); in_packet = pa; in_valid = 1'b1; queues_full = 4'b0010; at_neg();
        chk("t5_accept", 700'(in_ready), 700'(1));
        step(); in_valid = 1'b0; at_neg();
        chk("t5_stalled", 700'(stall), 700'(1));
        step(); reset = 1'b0; queues_full = '0; at_neg();
        chk("t5_rst_strobe", 700'(dv), 700'(0));
        chk("t5_rst_stall", 700'(stall), 700'(0));
        chk("t5_rst_ready", 700'(in_ready), 700'(0));
        step(); reset = 1'b1; at_neg();
        chk("t5_after_strobe", 700'(dv), 700'(0));
        chk("t5_after_empty", 700'(in_ready), 700'(1));
        chk("t5_after_bus", 700'(pkt), 700'(0));

        // Ten dispatches to queue 1 for the counters.
        for (int k = 0; k < 10; k++) begin
            step(); pa = mk(2'd1, 32'd100 + 32'(k)); in_packet = pa; in_valid = 1'b1;
            push(4'b0010, pa); at_neg();
            chk("t6_accept", 700'(in_ready), 700'(1));
            step(); in_valid = 1'b0; at_neg();
            chk("t6_fire", 700'(dv), 700'(4'b0010));
        end
        step(); at_neg();
`ifdef DISPATCH_STATS_EN
        exp_cnt = {32'd0, 32'd0, 32'd10, 32'd0};
`else
        exp_cnt = '0;
`endif
        chk("t6_counters", 700'(dispatched_count), 700'(exp_cnt));

        // Three-queue instance: ID 3 is dropped, next packet taken the same cycle.
        step(); in_packet3 = 16'h00a3; in_valid3 = 1'b1; push3(1'b1, 3'b000, 16'h00a3); at_neg();
        chk("t7_accept", 700'(in_ready3), 700'(1));
        step(); in_packet3 = 16'h0051; push3(1'b0, 3'b010, 16'h0051); at_neg();
        chk("t7_invalid", 700'(inv3), 700'(1));
        chk("t7_no_strobe", 700'(dv3), 700'(0));
        chk("t7_same_cycle_ready", 700'(in_ready3), 700'(1));
        chk("t7_no_stall", 700'(stall3), 700'(0));
        step(); in_valid3 = 1'b0; at_neg();
        chk("t7_invalid_once", 700'(inv3), 700'(0));
        chk("t7_next_fire", 700'(dv3), 700'(3'b010));
        step(); at_neg();
        chk("t7_idle", 700'(dv3), 700'(0));
`ifdef DISPATCH_STATS_EN
        exp_cnt3 = {32'd0, 32'd1, 32'd0};
`else
        exp_cnt3 = '0;
`endif
        chk("t7_counters", 700'(dispatched_count3), 700'(exp_cnt3));
        chk("sb_drained", 700'(sb.size()), 700'(0));
        chk("sb3_drained", 700'(sb3.size()), 700'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/packet_dispatcher.md
Name: packet_dispatcher

Overview:
- Producer end of the queueing domain's per-core queue interface.
- Accepts one packet per handshake from the upstream port and reads its target queue ID from a fixed bit field.
- Holds the packet in a one-entry stage register, checks queue-full and buffer-pool availability, then drives a shared packet bus plus a one-cycle one-hot write strobe into the queueing domain.
- Discards packets whose ID is out of range and flags them with an error pulse.

Parameters:
NUMBER_OF_QUEUES, 4, number of per-core queues; one-hot strobe width
DATA_SIZE, 678, packet width in bits
ID_OFFSET, 0, LSB position of the queue-ID field inside the packet; field width is $clog2(NUMBER_OF_QUEUES)
COUNTER_SIZE, 32, width of each statistics counter

Ports:
clock  input  1  single clock; all logic rising-edge
reset  input  1  synchronous, active-low reset
in_packet  input  DATA_SIZE  upstream packet
in_valid  input  1  upstream packet valid
in_ready  output  1  dispatcher can accept in_packet this cycle
queues_full  input  NUMBER_OF_QUEUES  per-queue full flags from the queueing domain
pool_empty  input  1  buffer availability pool depleted
pool_last  input  1  pool holds exactly one free slot
dispatcher_to_queues_packet  output  DATA_SIZE  staged packet, shared by all queues
dispatcher_to_queues_valid  output  NUMBER_OF_QUEUES  one-hot write strobe, one cycle per packet
invalid_id  output  1  one-cycle pulse when a packet is dropped for an out-of-range ID
stall  output  1  staged packet is blocked this cycle
dispatched_count  output  NUMBER_OF_QUEUES*COUNTER_SIZE  per-queue dispatch counters, queue i at bits [i*COUNTER_SIZE +: COUNTER_SIZE]

Behaviour:
- Reset (reset==0 sampled at a clock edge):
  - state=EMPTY, stage register=0, prev_fire=0, prev_q=0, counters=0.
  - Outputs: in_ready=0 during reset, dispatcher_to_queues_valid=0, invalid_id=0, stall=0, dispatcher_to_queues_packet=0.
- Reset mid-operation: a staged packet is discarded and no strobe is issued in the reset cycle.
- States:
  - EMPTY: nothing staged.
  - LOADED: stage holds a packet; q = stage[ID_OFFSET +: $clog2(NUMBER_OF_QUEUES)].
- Combinational decisions, evaluated in LOADED only:
  - bad = (q >= NUMBER_OF_QUEUES). Only reachable when NUMBER_OF_QUEUES is not a power of two.
  - hazard = prev_fire && ((prev_q == q) || prev_pool_last). Reason: full/empty flags settle one cycle after a push.
  - fire = !bad && !queues_full[q] && !pool_empty && !hazard.
  - drop = bad.
  - stall = LOADED && !fire && !drop.
- Outputs:
  - dispatcher_to_queues_valid = fire ? (1 << q) : 0. Combinational from registered state; zero-cycle latency from the stage register.
  - dispatcher_to_queues_packet = stage register at all times; valid is qualified only by the strobe.
  - invalid_id = drop.
  - in_ready = reset && (EMPTY || fire || drop). Gives full throughput with pass-through refill.
- Transitions:
  - EMPTY: in_valid && in_ready → LOADED, stage ← in_packet.
  - LOADED: (fire || drop) && in_valid → stay LOADED, stage ← in_packet.
  - LOADED: (fire || drop) && !in_valid → EMPTY.
  - LOADED: stall → hold; stage is unchanged.
- Registered each cycle: prev_fire ← fire, prev_q ← q, prev_pool_last ← pool_last && fire.
- Latency: packet accepted at edge t is dispatched no earlier than cycle t+1. Sustained rate is 1 packet/cycle when consecutive packets target different queues; 1 per 2 cycles to the same queue.
- The strobe is never multi-hot. At most one packet leaves per cycle.
- Backpressure: while stalled, upstream in_valid/in_packet may change freely because in_ready=0.

Optional Feature:
DISPATCH_STATS_EN
- Defined:
  - Counter i increments by 1 in every cycle where dispatcher_to_queues_valid[i]=1.
  - Counters wrap modulo 2^COUNTER_SIZE.
  - Counters are cleared only by reset.
  - Drops are not counted.
- Not defined: no counter registers are built and dispatched_count is tied to 0.

Test Plan:
- Reset, then packets with ID 2 and ID 0 back-to-back, all flags clear → strobe 4'b0100 at cycle t+1 and 4'b0001 at t+2; in_ready stays 1.
- Two packets to queue 1 back-to-back → strobe 4'b0010, then one stall cycle (stall=1, strobe 0), then 4'b0010.
- queues_full[3]=1 for 5 cycles with a packet to queue 3 staged → stall=1 and in_ready=0 for 5 cycles; strobe 4'b1000 in the cycle after full drops; packet bus unchanged throughout.
- pool_empty=1 with a packet staged → no strobe. Then pool_last=1 on a dispatch to queue 0 followed by a packet to queue 2 → one bubble cycle before queue 2 fires.
- NUMBER_OF_QUEUES=3, packet with ID 3 → invalid_id pulses once, no strobe, next packet accepted in the same cycle.
- Reset asserted while LOADED and stalled → next cycle strobe=0, state EMPTY. With DISPATCH_STATS_EN: 10 dispatches to queue 1 → dispatched_count field 1 = 10, all others 0.
